// File: rtl/glyph_font_pkg.sv
// Shared 5x7 font table, code constants and streamer state encoding.
// Hex glyphs A-F exist only when GLYPH_HEX_EN is defined; otherwise codes 10-15 fall outside the table.
package glyph_font_pkg;

  localparam int GLYPH_W_DEF = 5;
  localparam int GLYPH_H_DEF = 7;
  localparam int FONT_W      = 5;
  localparam int FONT_H      = 7;

  localparam logic [3:0] CODE_0 = 4'd0;
  localparam logic [3:0] CODE_1 = 4'd1;
  localparam logic [3:0] CODE_2 = 4'd2;
  localparam logic [3:0] CODE_3 = 4'd3;
  localparam logic [3:0] CODE_4 = 4'd4;
  localparam logic [3:0] CODE_5 = 4'd5;
  localparam logic [3:0] CODE_6 = 4'd6;
  localparam logic [3:0] CODE_7 = 4'd7;
  localparam logic [3:0] CODE_8 = 4'd8;
  localparam logic [3:0] CODE_9 = 4'd9;
  localparam logic [3:0] CODE_A = 4'd10;
  localparam logic [3:0] CODE_B = 4'd11;
  localparam logic [3:0] CODE_C = 4'd12;
  localparam logic [3:0] CODE_D = 4'd13;
  localparam logic [3:0] CODE_E = 4'd14;
  localparam logic [3:0] CODE_F = 4'd15;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  typedef logic [FONT_W-1:0] font_row_t;

`ifdef GLYPH_HEX_EN
  localparam int NUM_GLYPHS = 16;
`else
  localparam int NUM_GLYPHS = 10;
`endif

  // Row 0 is the top row; bit FONT_W-1 is the leftmost pixel.
  localparam font_row_t FONT_TBL [NUM_GLYPHS][FONT_H] = '{
    '{5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110},
    '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110},
    '{5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111},
    '{5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110},
    '{5'b01000, 5'b01100, 5'b01010, 5'b11111, 5'b01000, 5'b01000, 5'b00000},
    '{5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110},
    '{5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110},
    '{5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000},
    '{5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110},
    '{5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100}
`ifdef GLYPH_HEX_EN
    ,
    '{5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001},
    '{5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10001, 5'b10001, 5'b11110},
    '{5'b01110, 5'b10001, 5'b10000, 5'b10000, 5'b10000, 5'b10001, 5'b01110},
    '{5'b11100, 5'b10010, 5'b10001, 5'b10001, 5'b10001, 5'b10010, 5'b11100},
    '{5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111},
    '{5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b10000}
`endif
  };

  function automatic font_row_t font_lookup(input int code, input int row);
    font_row_t r;
    r = '0;
    if (code >= 0 && code < NUM_GLYPHS && row >= 0 && row < FONT_H)
      r = FONT_TBL[code][row];
    return r;
  endfunction

endpackage

// File: rtl/glyph_font_rom.sv
// Combinational font lookup (code,row -> GLYPH_W-bit row, left aligned); zero latency, no flow control.
// Rows >= GLYPH_H and codes without a glyph (A-F unless GLYPH_HEX_EN) read as blank.
module glyph_font_rom
  import glyph_font_pkg::*;
#(
  parameter int GLYPH_W = GLYPH_W_DEF,
  parameter int GLYPH_H = GLYPH_H_DEF,
  parameter int ROW_W   = 3
) (
  input  logic [3:0]         code,
  input  logic [ROW_W-1:0]   row,
  output logic [GLYPH_W-1:0] bits
);

  font_row_t raw;

  always_comb begin
    raw = '0;
    if (int'(row) < GLYPH_H)
      raw = font_lookup(int'(code), int'(row));
  end

  // The stored font is FONT_W wide; pad on the right or drop right-hand columns to fit.
  generate
    if (GLYPH_W == FONT_W) begin : g_exact
      assign bits = raw;
    end else if (GLYPH_W > FONT_W) begin : g_pad
      assign bits = {raw, {(GLYPH_W-FONT_W){1'b0}}};
    end else begin : g_trunc
      assign bits = raw[FONT_W-1 -: GLYPH_W];
    end
  endgenerate

endmodule

// File: rtl/glyph_row_streamer.sv
// Streams one glyph row as GLYPH_W*SCALE_X pixels; first pixel 2 cycles after request accept (GLYPH_HEX_EN adds A-F).
// Valid/ready output: pixel, pix_last and counters hold while pix_ready is low; req_ready only in IDLE.
module glyph_row_streamer
  import glyph_font_pkg::*;
#(
  parameter int GLYPH_W = GLYPH_W_DEF,
  parameter int GLYPH_H = GLYPH_H_DEF,
  parameter int ROW_W   = 3,
  parameter int SCALE_X = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_code,
  input  logic [ROW_W-1:0] req_row,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_on,
  output logic             pix_last
);

  localparam int CW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int RW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam logic [CW-1:0] COL_LAST   = CW'(GLYPH_W - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(SCALE_X - 1);
  localparam logic          FIRST_LAST = (GLYPH_W == 1) && (SCALE_X == 1);

  state_t             state;
  logic [3:0]         code_q;
  logic [ROW_W-1:0]   row_q;
  logic [GLYPH_W-1:0] sr;
  logic [GLYPH_W-1:0] rom_bits;
  logic [CW-1:0]      col_cnt;
  logic [RW-1:0]      rep_cnt;

  logic               rep_wrap;
  logic [CW-1:0]      nxt_col;
  logic [RW-1:0]      nxt_rep;
  logic [GLYPH_W-1:0] nxt_sr;

  glyph_font_rom #(
    .GLYPH_W (GLYPH_W),
    .GLYPH_H (GLYPH_H),
    .ROW_W   (ROW_W)
  ) u_rom (
    .code (code_q),
    .row  (row_q),
    .bits (rom_bits)
  );

  // Next-pixel view, so pix_on/pix_last can be registered one step ahead.
  always_comb begin
    rep_wrap = (rep_cnt == REP_LAST);
    nxt_rep  = rep_wrap ? '0 : rep_cnt + 1'b1;
    nxt_col  = rep_wrap ? col_cnt + 1'b1 : col_cnt;
    nxt_sr   = rep_wrap ? (sr << 1) : sr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      pix_valid <= 1'b0;
      pix_on    <= 1'b0;
      pix_last  <= 1'b0;
      code_q    <= '0;
      row_q     <= '0;
      sr        <= '0;
      col_cnt   <= '0;
      rep_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            code_q    <= req_code;
            row_q     <= req_row;
            req_ready <= 1'b0;
            state     <= LOAD;
          end else begin
            req_ready <= 1'b1;
          end
        end
        LOAD: begin
          sr        <= rom_bits;
          col_cnt   <= '0;
          rep_cnt   <= '0;
          pix_valid <= 1'b1;
          pix_on    <= rom_bits[GLYPH_W-1];
          pix_last  <= FIRST_LAST;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (pix_ready) begin
            if (pix_last) begin
              pix_valid <= 1'b0;
              pix_on    <= 1'b0;
              pix_last  <= 1'b0;
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              sr       <= nxt_sr;
              col_cnt  <= nxt_col;
              rep_cnt  <= nxt_rep;
              pix_on   <= nxt_sr[GLYPH_W-1];
              pix_last <= (nxt_col == COL_LAST) && (nxt_rep == REP_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_row_streamer.sv
// Directed bench for glyph_row_streamer: one instance at SCALE_X=1, one at SCALE_X=2, sharing clock and reset.
module tb_glyph_row_streamer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] pix_ready;
  logic [3:0] req_code [2];
  logic [2:0] req_row  [2];
  wire  [1:0] req_ready;
  wire  [1:0] pix_valid;
  wire  [1:0] pix_on;
  wire  [1:0] pix_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  glyph_row_streamer #(.SCALE_X(1)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_code  (req_code[0]),
    .req_row   (req_row[0]),
    .pix_valid (pix_valid[0]),
    .pix_ready (pix_ready[0]),
    .pix_on    (pix_on[0]),
    .pix_last  (pix_last[0])
  );

  glyph_row_streamer #(.SCALE_X(2)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_code  (req_code[1]),
    .req_row   (req_row[1]),
    .pix_valid (pix_valid[1]),
    .pix_ready (pix_ready[1]),
    .pix_on    (pix_on[1]),
    .pix_last  (pix_last[1])
  );

  // s: instance (0 -> SCALE_X=1, 1 -> SCALE_X=2); rdy bit i = pix_ready on stream cycle i;
  // exp holds the expected pixel stream left-aligned (first pixel in bit 15).
  typedef struct {
    string      name;
    int         s;
    logic [3:0] code;
    logic [2:0] row;
    logic [15:0] rdy;
    int         len;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge with the selected instance idle.
  task automatic run_vec(input vec_t v);
    int idx;
    int cyc;
    chk({v.name, "/req_ready"}, 32'(req_ready[v.s]), 32'd1);
    req_valid[v.s] = 1'b1;
    req_code[v.s]  = v.code;
    req_row[v.s]   = v.row;
    @(negedge clk);
    req_valid[v.s] = 1'b0;
    req_code[v.s]  = ~v.code;
    req_row[v.s]   = ~v.row;
    chk({v.name, "/load_vld"}, 32'(pix_valid[v.s]), 32'd0);
    chk({v.name, "/load_rdy"}, 32'(req_ready[v.s]), 32'd0);
    @(negedge clk);
    idx = 0;
    cyc = 0;
    while (idx < v.len && cyc < 64) begin
      pix_ready[v.s] = (cyc < 16) ? v.rdy[cyc] : 1'b1;
      chk({v.name, "/vld"},  32'(pix_valid[v.s]), 32'd1);
      chk({v.name, "/on"},   32'(pix_on[v.s]),    32'(v.exp[15-idx]));
      chk({v.name, "/last"}, 32'(pix_last[v.s]),  32'(idx == v.len - 1));
      if (pix_ready[v.s]) idx++;
      cyc++;
      @(negedge clk);
    end
    pix_ready[v.s] = 1'b1;
    chk({v.name, "/accepted"}, 32'(idx), 32'(v.len));
    chk({v.name, "/end_vld"},  32'(pix_valid[v.s]), 32'd0);
    chk({v.name, "/end_rdy"},  32'(req_ready[v.s]), 32'd1);
  endtask

  initial begin
    vecs[0] = '{"c4r3",    0, 4'd4,  3'd3, 16'hFFFF,             5,  16'b1111_1000_0000_0000};
    vecs[1] = '{"c4r1",    0, 4'd4,  3'd1, 16'hFFFF,             5,  16'b0110_0000_0000_0000};
    vecs[2] = '{"x2_c4r2", 1, 4'd4,  3'd2, 16'hFFFF,             10, 16'b0011_0011_0000_0000};
    vecs[3] = '{"bp_c4r1", 0, 4'd4,  3'd1, 16'b1111_1111_1111_0001, 5, 16'b0110_0000_0000_0000};
    vecs[4] = '{"row7",    0, 4'd4,  3'd7, 16'hFFFF,             5,  16'b0000_0000_0000_0000};
`ifdef GLYPH_HEX_EN
    vecs[5] = '{"c12r0",   0, 4'd12, 3'd0, 16'hFFFF,             5,  16'b0111_0000_0000_0000};
`else
    vecs[5] = '{"c12r0",   0, 4'd12, 3'd0, 16'hFFFF,             5,  16'b0000_0000_0000_0000};
`endif
    vecs[6] = '{"bp_x2_c4r0", 1, 4'd4, 3'd0, 16'b1111_1111_1101_1011, 10, 16'b0011_0000_0000_0000};

    rst_n       = 1'b0;
    req_valid   = 2'b00;
    pix_ready   = 2'b11;
    req_code[0] = 4'd0;
    req_code[1] = 4'd0;
    req_row[0]  = 3'd0;
    req_row[1]  = 3'd0;

    // Reset held for three cycles: every output low on both instances.
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", 32'({req_ready, pix_valid, pix_on, pix_last}), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_release", 32'(req_ready), 32'h3);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset two pixels into a stream: stream aborts, no pix_last, then a fresh stream works.
    req_valid[0] = 1'b1;
    req_code[0]  = 4'd4;
    req_row[0]   = 3'd3;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("mid/p0_vld", 32'(pix_valid[0]), 32'd1);
    @(negedge clk);
    chk("mid/p1_vld", 32'(pix_valid[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid/rst_vld",  32'(pix_valid[0]), 32'd0);
    chk("mid/rst_last", 32'(pix_last[0]),  32'd0);
    chk("mid/rst_rdy",  32'(req_ready[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid/rdy_after", 32'(req_ready[0]), 32'd1);
    run_vec(vecs[1]);
    run_vec(vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
